// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the iterative restoring divider.
// The divider's state encoding and its step-counter width live here so that
// the top level and any future siblings agree on them.
package seq_divider_pkg;

   // Top-level controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Width of the step counter for a given operand width.
   // The counter runs 0..width-1, so $clog2(width) bits suffice.
   // The result is kept at least 1 so the counter never collapses to zero bits.
   function automatic int div_cnt_width(input int width);
      int w;
      w = $clog2(width);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/seq_divider_step.sv
// div_step: one combinational restoring-division step.
// Shifts {partial remainder, working quotient} left by one, trial-subtracts
// the divisor at WIDTH+1 bits, and keeps the difference only when it is
// non-negative. The freed quotient LSB receives the new quotient bit.
module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] prem,
   input  logic [WIDTH-1:0] wquo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] prem_next,
   output logic [WIDTH-1:0] wquo_next
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] trial;
   logic             borrow;
   logic             unused_trial_msb;

   // Shift, trial subtract, then restore on borrow
   always_comb begin
      shifted = {prem, wquo[WIDTH-1]};
      // One extra guard bit so the borrow shows up as the sign of the result
      trial   = {1'b0, shifted} - {2'b00, divisor};
      borrow  = trial[WIDTH+1];
      if (borrow) begin
         prem_next = shifted[WIDTH-1:0];
      end else begin
         prem_next = trial[WIDTH-1:0];
      end
      wquo_next = {wquo[WIDTH-2:0], ~borrow};
   end

   // When no borrow occurs the difference is below the divisor, so this bit is always 0
   assign unused_trial_msb = trial[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring divider, one quotient bit per clock,
// behind valid/ready input and output handshakes.
// Optional build macro: SEQ_DIVIDER_SIGNED_EN selects two's-complement
// operands/results (magnitude division plus sign fix-up on DONE entry).
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = div_cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   div_state_t       state_reg, state_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [WIDTH-1:0] prem_reg, prem_next;
   logic [WIDTH-1:0] wquo_reg, wquo_next;
   logic [WIDTH-1:0] dvsr_reg, dvsr_next;
   logic [WIDTH-1:0] quotient_reg, quotient_next;
   logic [WIDTH-1:0] remainder_reg, remainder_next;
   logic             dbz_reg, dbz_next;
   logic [WIDTH-1:0] step_prem, step_wquo;
   logic [WIDTH-1:0] dividend_mag, divisor_mag;
   logic [WIDTH-1:0] quotient_fix, remainder_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic neg_q_reg, neg_q_next;
   logic neg_r_reg, neg_r_next;

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
      return ~v + WIDTH'(1);
   endfunction

   // Magnitudes of the operands; -2^(WIDTH-1) maps onto itself, which is
   // still the correct magnitude when read as unsigned
   always_comb begin
      dividend_mag  = dividend[WIDTH-1] ? negate(dividend) : dividend;
      divisor_mag   = divisor[WIDTH-1]  ? negate(divisor)  : divisor;
      quotient_fix  = neg_q_reg ? negate(step_wquo) : step_wquo;
      remainder_fix = neg_r_reg ? negate(step_prem) : step_prem;
   end

   // Result signs, captured on acceptance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
      end else begin
         neg_q_reg <= neg_q_next;
         neg_r_reg <= neg_r_next;
      end
   end
`else
   // Unsigned build: operands and results pass straight through
   always_comb begin
      dividend_mag  = dividend;
      divisor_mag   = divisor;
      quotient_fix  = step_wquo;
      remainder_fix = step_prem;
   end
`endif

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .prem      (prem_reg),
      .wquo      (wquo_reg),
      .divisor   (dvsr_reg),
      .prem_next (step_prem),
      .wquo_next (step_wquo)
   );

   // State, counter, working and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         prem_reg      <= '0;
         wquo_reg      <= '0;
         dvsr_reg      <= '0;
         quotient_reg  <= '0;
         remainder_reg <= '0;
         dbz_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         prem_reg      <= prem_next;
         wquo_reg      <= wquo_next;
         dvsr_reg      <= dvsr_next;
         quotient_reg  <= quotient_next;
         remainder_reg <= remainder_next;
         dbz_reg       <= dbz_next;
      end
   end

   // Next-state and datapath updates; results load only on DONE entry
   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      prem_next      = prem_reg;
      wquo_next      = wquo_reg;
      dvsr_next      = dvsr_reg;
      quotient_next  = quotient_reg;
      remainder_next = remainder_reg;
      dbz_next       = dbz_reg;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q_next     = neg_q_reg;
      neg_r_next     = neg_r_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               if (divisor == '0) begin
                  // No iterations needed; the result is fixed by definition
                  state_next     = DONE;
                  quotient_next  = '1;
                  remainder_next = dividend;
                  dbz_next       = 1'b1;
               end else begin
                  state_next = CALC;
                  cnt_next   = '0;
                  prem_next  = '0;
                  wquo_next  = dividend_mag;
                  dvsr_next  = divisor_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
                  neg_q_next = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  neg_r_next = dividend[WIDTH-1];
`endif
               end
            end
         end
         CALC: begin
            prem_next = step_prem;
            wquo_next = step_wquo;
            cnt_next  = cnt_reg + CW'(1);
            if (cnt_reg == LAST_STEP) begin
               // Final step result goes straight into the output registers
               state_next     = DONE;
               quotient_next  = quotient_fix;
               remainder_next = remainder_fix;
               dbz_next       = 1'b0;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign in_ready    = (state_reg == IDLE);
   assign out_valid   = (state_reg == DONE);
   assign quotient    = quotient_reg;
   assign remainder   = remainder_reg;
   assign div_by_zero = dbz_reg;

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative restoring divider, WIDTH-bit dividend by WIDTH-bit divisor, one quotient bit per clock. It is the inverse companion to the combinational schoolbook multiplier in the arithmetic library. The block sits behind a valid/ready input and output handshake so datapaths can stall it. It is sized for small widths, where area matters more than latency.

## Interface
- WIDTH, 8, operand, quotient and remainder width; legal values are 2 to 32.
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  the dividend/divisor pair is presented.
- in_ready  output  1  the block can accept an operation; high only in IDLE.
- dividend  input  WIDTH  numerator; sampled on acceptance.
- divisor  input  WIDTH  denominator; sampled on acceptance.
- out_valid  output  1  the result is available; high only in DONE.
- out_ready  input  1  the consumer takes the result.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- div_by_zero  output  1  the accepted divisor was 0; qualified by out_valid.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - in_valid=1 accepts the operands.
  - divisor≠0 → CALC, with the step counter at 0, the partial remainder at 0 and the working quotient at the dividend.
  - divisor=0 → DONE directly, with quotient all-ones, remainder = dividend and div_by_zero=1.
- CALC step, once per cycle:
  - Shift {partial remainder, working quotient} left by 1.
  - Compute trial = partial remainder − divisor, at WIDTH+1 bits.
  - If trial ≥ 0, the partial remainder becomes trial and the quotient LSB is 1; otherwise the partial remainder is kept and the quotient LSB is 0.
  - After step WIDTH−1 → DONE.
- DONE:
  - Outputs are held stable.
  - out_ready=1 → IDLE.
  - in_ready stays 0 in the same cycle; there is no accept/retire overlap.
- Inputs are ignored outside of an IDLE acceptance. Changes to dividend/divisor during CALC have no effect.
- Result invariant for the unsigned build: dividend = quotient·divisor + remainder, with remainder < divisor.

## Timing
- Reset values: in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, state=IDLE.
- Reset asserted in any state, including mid-CALC or in DONE with the result unconsumed: the operation is abandoned and all outputs return to their reset values immediately.
- Normal latency:
  - Acceptance at edge k → out_valid=1 after edge k+WIDTH.
  - That gives WIDTH CALC cycles.
- Divide-by-zero latency: out_valid=1 after edge k+1.
- Retire at the edge where out_valid & out_ready. in_ready=1 after that edge. The next acceptance happens at the earliest one edge later.
- Throughput: one operation per WIDTH+2 cycles with out_ready held high.
- quotient, remainder and div_by_zero change only on entry to DONE or on reset; never while out_valid=1.

## Configuration
- SEQ_DIVIDER_SIGNED_EN defined:
  - Operands and results are two's complement.
  - Operand magnitudes are taken on acceptance.
  - The magnitude division proceeds as in the unsigned build.
  - Signs are fixed up on DONE entry, with no extra cycle.
  - The quotient truncates toward zero; the remainder takes the sign of the dividend.
  - −2^(WIDTH−1) / −1 gives quotient −2^(WIDTH−1) (wraps) and remainder 0.
  - Divide by zero gives quotient −1 (all-ones), remainder = dividend and div_by_zero=1.
- Undefined: unsigned operation only, and the sign logic is absent.

## Structure
- Shared package seq_divider_pkg holds:
  - the state enum div_state_t {IDLE, CALC, DONE};
  - the counter width function/constant, $clog2(WIDTH).
- One sub-module, div_step:
  - Purely combinational; performs a single shift/trial-subtract/select.
  - Inputs: partial remainder, working quotient, divisor.
  - Outputs: next partial remainder, next working quotient.
- Top level: FSM, step counter, operand/result registers, handshake, and the optional sign logic.

## Test plan
- WIDTH=8, 100/7, out_ready=1 → out_valid exactly 8 cycles after accept; quotient=14, remainder=2, div_by_zero=0.
- 55/0 → out_valid 1 cycle after accept; quotient=255, remainder=55, div_by_zero=1.
- 200/13 with out_ready=0 for 5 cycles in DONE → quotient=15 and remainder=5 held stable; in_ready=0 throughout; retire on the first out_ready=1.
- Reset pulse at CALC step 4 of 255/1 → outputs 0 and in_ready=1 at once; a following 255/1 returns quotient=255, remainder=0.
- Back-to-back: two operations offered with in_valid held high → the second is accepted exactly one cycle after the first retires.
- SEQ_DIVIDER_SIGNED_EN: −7/2 → quotient=0xFD (−3), remainder=0xFF (−1); −128/−1 → quotient=0x80, remainder=0.
